// File: rtl/opm_pkg.sv
// Shared types and constant helpers for the outer-product multiply/accumulate block.
package opm_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_e;

  localparam int MAX_OW = 64;

  function automatic int calc_ow(input int dw, input int guard);
    return 2 * dw + guard;
  endfunction

  function automatic int elem_idx(input int i, input int j, input int b_cnt);
    return i * b_cnt + j;
  endfunction

  // Largest representable value in an ow-bit field (signed keeps the sign bit clear).
  function automatic logic [MAX_OW-1:0] sat_hi(input int ow, input logic sgn);
    logic [MAX_OW-1:0] v;
    v = '0;
    for (int n = 0; n < MAX_OW; n++)
      if (n < ow - (sgn ? 1 : 0)) v[n] = 1'b1;
    return v;
  endfunction

  function automatic logic [MAX_OW-1:0] sat_lo(input int ow, input logic sgn);
    logic [MAX_OW-1:0] v;
    v = '0;
    for (int n = 0; n < MAX_OW; n++)
      if (sgn && n == ow - 1) v[n] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/opm_mac_cell.sv
// One outer-product element: product, saturating accumulate and sticky saturation bit.
module opm_mac_cell
  import opm_pkg::*;
#(
  parameter int DW = 8,
  parameter int OW = 17
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          add,
  input  logic          sgn,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [OW-1:0] acc,
  output logic          sat
);

  localparam logic [MAX_OW-1:0] HI_U_W = sat_hi(OW, 1'b0);
  localparam logic [MAX_OW-1:0] HI_S_W = sat_hi(OW, 1'b1);
  localparam logic [MAX_OW-1:0] LO_S_W = sat_lo(OW, 1'b1);
  localparam logic [OW-1:0]     HI_U   = HI_U_W[OW-1:0];
  localparam logic [OW-1:0]     HI_S   = HI_S_W[OW-1:0];
  localparam logic [OW-1:0]     LO_S   = LO_S_W[OW-1:0];

  logic [OW-1:0] a_x, b_x, prod, sum_sat;
  logic [OW:0]   sum;
  logic          ovf;

  // OW >= 2*DW, so the product modulo 2^OW of the extended operands is exact.
  assign a_x  = {{(OW-DW){sgn & a[DW-1]}}, a};
  assign b_x  = {{(OW-DW){sgn & b[DW-1]}}, b};
  assign prod = a_x * b_x;

  assign sum = {sgn & acc[OW-1], acc} + {sgn & prod[OW-1], prod};
  assign ovf = sgn ? (sum[OW] ^ sum[OW-1]) : sum[OW];

  always_comb begin
    sum_sat = sum[OW-1:0];
    if (ovf) begin
      if (!sgn)        sum_sat = HI_U;
      else if (sum[OW]) sum_sat = LO_S;
      else             sum_sat = HI_S;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (load) begin
      acc <= prod;
      sat <= 1'b0;
    end else if (add) begin
      acc <= sum_sat;
      sat <= sat | ovf;
    end
  end

endmodule

// File: rtl/outer_product_mac.sv
// Pipelined A_CNT x B_CNT outer-product multiplier with optional saturating accumulation
// and valid/ready flow control; the element array doubles as the output register.
module outer_product_mac
  import opm_pkg::*;
#(
  parameter  int A_CNT     = 3,
  parameter  int B_CNT     = 3,
  parameter  int DW        = 8,
  parameter  int GUARD     = 1,
  parameter  int MAX_BEATS = 16,
  localparam int OW        = calc_ow(DW, GUARD)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     signed_mode,
  input  logic                     acc_mode,
  input  logic                     acc_last,
  input  logic [A_CNT*DW-1:0]      a_bus,
  input  logic [B_CNT*DW-1:0]      b_bus,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [A_CNT*B_CNT*OW-1:0] c_bus,
  output logic [A_CNT*B_CNT-1:0]   sat_flag
);

  localparam int            CW      = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);

  logic                en, fire;
  logic                p_valid_reg, p_signed_reg, p_acc_reg, p_last_reg;
  logic [A_CNT*DW-1:0] a_reg;
  logic [B_CNT*DW-1:0] b_reg;
  acc_state_e          state_reg, state_next;
  logic [CW-1:0]       beat_cnt_reg, beat_cnt_next;
  logic                sgn_reg, sgn_next;
  logic                out_valid_reg, out_valid_next;
  logic                load, add, emit, mul_sgn;

  assign en        = ~out_valid_reg | out_ready;
  assign in_ready  = en;
  assign fire      = en & p_valid_reg;
  assign out_valid = out_valid_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_valid_reg  <= 1'b0;
      p_signed_reg <= 1'b0;
      p_acc_reg    <= 1'b0;
      p_last_reg   <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
    end else if (en) begin
      p_valid_reg <= in_valid;
      if (in_valid) begin
        p_signed_reg <= signed_mode;
        p_acc_reg    <= acc_mode;
        p_last_reg   <= acc_last;
        a_reg        <= a_bus;
        b_reg        <= b_bus;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      beat_cnt_reg  <= '0;
      sgn_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      beat_cnt_reg  <= beat_cnt_next;
      sgn_reg       <= sgn_next;
      out_valid_reg <= out_valid_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    beat_cnt_next = beat_cnt_reg;
    sgn_next      = sgn_reg;
    load          = 1'b0;
    add           = 1'b0;
    emit          = 1'b0;
    mul_sgn       = sgn_reg;
    case (state_reg)
      IDLE: begin
        mul_sgn = p_signed_reg;
        if (fire) begin
          load = 1'b1;
          if (!p_acc_reg) begin
            emit = 1'b1;
          end else begin
            sgn_next      = p_signed_reg;
            beat_cnt_next = CW'(1);
            if (p_last_reg || MAX_BEATS == 1) emit = 1'b1;
            else                              state_next = ACCUM;
          end
        end
      end
      ACCUM: begin
        // A non-accumulating beat here closes the running sum as its final term.
        if (fire) begin
          add           = 1'b1;
          beat_cnt_next = beat_cnt_reg + CW'(1);
          if (!p_acc_reg || p_last_reg || beat_cnt_next == MAX_CNT) begin
            emit       = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    out_valid_next = en ? emit : out_valid_reg;
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < A_CNT; gi++) begin : g_row
      for (gj = 0; gj < B_CNT; gj++) begin : g_col
        localparam int K = elem_idx(gi, gj, B_CNT);
        opm_mac_cell #(
          .DW(DW),
          .OW(OW)
        ) u_cell (
          .clk  (clk),
          .reset(reset),
          .load (load),
          .add  (add),
          .sgn  (mul_sgn),
          .a    (a_reg[gi*DW +: DW]),
          .b    (b_reg[gj*DW +: DW]),
          .acc  (c_bus[K*OW +: OW]),
          .sat  (sat_flag[K])
        );
      end
    end
  endgenerate

endmodule

// File: tb/tb_outer_product_mac.sv
// Directed self-checking bench for outer_product_mac (3x3, 8-bit, MAX_BEATS=4).
module tb_outer_product_mac;

  localparam int A_CNT = 3, B_CNT = 3, DW = 8, GUARD = 1, MAX_BEATS = 4;
  localparam int OW = 2 * DW + GUARD;
  localparam int NE = A_CNT * B_CNT;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 in_valid = 1'b0, signed_mode = 1'b0, acc_mode = 1'b0, acc_last = 1'b0;
  logic                 out_ready = 1'b1;
  logic                 in_ready, out_valid;
  logic [A_CNT*DW-1:0]  a_bus = '0;
  logic [B_CNT*DW-1:0]  b_bus = '0;
  logic [NE*OW-1:0]     c_bus;
  logic [NE-1:0]        sat_flag;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  outer_product_mac #(
    .A_CNT(A_CNT), .B_CNT(B_CNT), .DW(DW), .GUARD(GUARD), .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .signed_mode(signed_mode), .acc_mode(acc_mode), .acc_last(acc_last),
    .a_bus(a_bus), .b_bus(b_bus), .out_valid(out_valid), .out_ready(out_ready),
    .c_bus(c_bus), .sat_flag(sat_flag)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] elem(input int k);
    return c_bus[k*OW +: OW];
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] a, input logic [23:0] b,
                      input logic sm, input logic am, input logic al);
    a_bus = a; b_bus = b; signed_mode = sm; acc_mode = am; acc_last = al;
    in_valid = 1'b1;
    next_cycle();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, " out_valid"}, 64'(out_valid), 64'd1);
  endtask

  task automatic check_all(input string tag, input logic [OW-1:0] v, input logic s);
    for (int k = 0; k < NE; k++) check($sformatf("%s c%0d", tag, k), 64'(elem(k)), 64'(v));
    check({tag, " sat_flag"}, 64'(sat_flag), s ? 64'((1 << NE) - 1) : 64'd0);
    $display("txn %s: c0=0x%0h sat=0x%0h", tag, elem(0), sat_flag);
  endtask

  int exp_u[NE] = '{4, 5, 6, 8, 10, 12, 12, 15, 18};
  int exp_bp[6] = '{2, 6, 12, 20, 30, 42};
  logic [OW-1:0] cap_c0;
  logic [NE-1:0] cap_sat;
  int pulses, idx, rcv;
  logic acc_ok;

  initial begin
    // Reset state
    #12;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset c_bus nonzero", 64'(|c_bus), 64'd0);
    check("reset sat_flag", 64'(sat_flag), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
    check("reset in_ready", 64'(in_ready), 64'd1);

    // Unsigned single beat with 2-cycle latency
    send({8'd3, 8'd2, 8'd1}, {8'd6, 8'd5, 8'd4}, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("unsigned latency1", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("unsigned latency2", 64'(out_valid), 64'd1);
    for (int k = 0; k < NE; k++) check($sformatf("unsigned c%0d", k), 64'(elem(k)), 64'(exp_u[k]));
    check("unsigned sat_flag", 64'(sat_flag), 64'd0);
    $display("txn unsigned: c8=%0d", elem(8));
    @(negedge clk);
    check("unsigned out_valid drop", 64'(out_valid), 64'd0);

    // Signed single beat, mixed signs
    next_cycle();
    send({8'h00, 8'h80, 8'hFF}, {8'h00, 8'h7F, 8'h80}, 1'b1, 1'b0, 1'b0);
    wait_valid("signed");
    check("signed c0", 64'(elem(0)), 64'h00080);
    check("signed c1", 64'(elem(1)), 64'h1FF81);
    check("signed c3", 64'(elem(3)), 64'h04000);
    check("signed c4", 64'(elem(4)), 64'h1C080);
    check("signed sat_flag", 64'(sat_flag), 64'd0);
    $display("txn signed: c4=0x%0h", elem(4));

    // Unsigned accumulate 3 x 255*255 saturates, exactly one pulse
    next_cycle();
    send({3{8'hFF}}, {3{8'hFF}}, 1'b0, 1'b1, 1'b0);
    send({3{8'hFF}}, {3{8'hFF}}, 1'b0, 1'b1, 1'b0);
    send({3{8'hFF}}, {3{8'hFF}}, 1'b0, 1'b1, 1'b1);
    pulses = 0;
    cap_c0 = '0;
    cap_sat = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (pulses == 0) begin
          for (int k = 0; k < NE; k++) check($sformatf("usat c%0d", k), 64'(elem(k)), 64'd131071);
          cap_c0 = elem(0);
          cap_sat = sat_flag;
        end
        pulses++;
      end
    end
    check("usat pulses", 64'(pulses), 64'd1);
    check("usat sat_flag", 64'(cap_sat), 64'h1FF);
    $display("txn usat: c0=%0d pulses=%0d", cap_c0, pulses);

    // Forced emit at MAX_BEATS, then a fresh accumulation
    next_cycle();
    for (int n = 0; n < 4; n++) send({3{8'd1}}, {3{8'd1}}, 1'b0, 1'b1, 1'b0);
    wait_valid("maxbeats");
    check_all("maxbeats", 17'd4, 1'b0);
    next_cycle();
    send({3{8'd1}}, {3{8'd1}}, 1'b0, 1'b1, 1'b1);
    wait_valid("maxbeats next");
    check_all("maxbeats next", 17'd1, 1'b0);

    // Non-accumulating beat terminates a running sum: 1 + 1 + 4
    next_cycle();
    send({3{8'd1}}, {3{8'd1}}, 1'b0, 1'b1, 1'b0);
    send({3{8'd1}}, {3{8'd1}}, 1'b0, 1'b1, 1'b0);
    send({3{8'd2}}, {3{8'd2}}, 1'b0, 1'b0, 1'b0);
    wait_valid("terminate");
    check_all("terminate", 17'd6, 1'b0);

    // Latched signed mode: (-1)*(-1) twice, second beat claims unsigned
    next_cycle();
    send({3{8'hFF}}, {3{8'hFF}}, 1'b1, 1'b1, 1'b0);
    send({3{8'hFF}}, {3{8'hFF}}, 1'b0, 1'b1, 1'b1);
    wait_valid("latched sign");
    check_all("latched sign", 17'd2, 1'b0);

    // Signed positive saturation: 4 x 16384 = 65536 > 65535
    next_cycle();
    for (int n = 0; n < 4; n++) send({3{8'h80}}, {3{8'h80}}, 1'b1, 1'b1, 1'b0);
    wait_valid("ssat");
    check_all("ssat", 17'h0FFFF, 1'b1);

    // Backpressure: 6 beats, output stalled for 5 cycles
    next_cycle();
    idx = 0;
    rcv = 0;
    for (int cyc = 0; cyc < 60 && rcv < 6; cyc++) begin
      if (idx < 6) begin
        a_bus = {16'd0, 8'(idx + 1)};
        b_bus = {16'd0, 8'(idx + 2)};
        signed_mode = 1'b0; acc_mode = 1'b0; acc_last = 1'b0;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (cyc >= 7);
      @(negedge clk);
      if (cyc >= 2 && cyc < 7) begin
        check($sformatf("bp in_ready cyc%0d", cyc), 64'(in_ready), 64'd0);
        check($sformatf("bp hold cyc%0d", cyc), 64'(elem(0)), 64'(exp_bp[0]));
      end
      acc_ok = in_valid & in_ready;
      if (out_valid && out_ready) begin
        check($sformatf("bp result%0d", rcv), 64'(elem(0)), 64'(exp_bp[rcv]));
        $display("txn bp result%0d: c0=%0d", rcv, elem(0));
        rcv++;
      end
      next_cycle();
      if (acc_ok) idx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp received", 64'(rcv), 64'd6);

    // Asynchronous reset mid-accumulation
    send({3{8'd3}}, {3{8'd3}}, 1'b0, 1'b1, 1'b0);
    send({3{8'd3}}, {3{8'd3}}, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst c_bus nonzero", 64'(|c_bus), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
    send({3{8'd2}}, {3{8'd2}}, 1'b0, 1'b1, 1'b1);
    wait_valid("post reset");
    check_all("post reset", 17'd4, 1'b0);

    next_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/outer_product_mac.md
Name: outer_product_mac

Overview:
Parametrised, pipelined outer-product multiplier with optional accumulation. Each element is c[i][j] = a[i]*b[j] over A_CNT x B_CNT channels. It generalises the fixed 3x3, 8-bit, 17-bit-result multiplier. It adds signed mode, multi-beat accumulation with saturation, and valid/ready flow control, and sits between operand sources and downstream matrix logic.

Parameters:
A_CNT, 3, number of a operands (rows)
B_CNT, 3, number of b operands (columns)
DW, 8, operand width in bits
GUARD, 1, accumulator guard bits; OW = 2*DW+GUARD (default 17)
MAX_BEATS, 16, max beats per accumulation before a forced emit (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  operand beat valid
in_ready  out  1  block accepts a beat this cycle
signed_mode  in  1  1 = two's-complement operands, 0 = unsigned
acc_mode  in  1  1 = accumulate beats, 0 = one result per beat
acc_last  in  1  final beat of an accumulation; ignored when acc_mode=0
a_bus  in  A_CNT*DW  a[i] at a_bus[i*DW +: DW]
b_bus  in  B_CNT*DW  b[j] at b_bus[j*DW +: DW]
out_valid  out  1  c_bus holds a result
out_ready  in  1  downstream accepts the result
c_bus  out  A_CNT*B_CNT*OW  element k=i*B_CNT+j at c_bus[k*OW +: OW]
sat_flag  out  A_CNT*B_CNT  per-element saturation occurred in this result

Behaviour:
- Reset (reset=0, async): all pipeline, accumulator and counter registers cleared. out_valid=0, c_bus=0, sat_flag=0, in_ready=1 once released. Any partial accumulation is discarded.
- Global advance enable: en = ~out_valid | out_ready. in_ready = en. All stages advance only when en=1. A beat is accepted when in_valid & in_ready.
- Stage 1 (P): register the products and the beat's mode/last tags. Signed products are sign-extended to OW; unsigned products are zero-extended.
- Stage 2 (A), state machine IDLE/ACCUM:
  - acc_mode=0 beat: c = product, sat_flag=0, out_valid=1. Latency is 2 cycles from acceptance to out_valid.
  - acc_mode=1 beat in IDLE: acc = product. Latch signed_mode, clear sat_flag, beat_cnt=1. Go to ACCUM unless acc_last=1 or MAX_BEATS=1, in which case emit.
  - Beat in ACCUM: acc = sat(acc + product) using the latched signed_mode; a signed_mode change mid-accumulation is ignored. beat_cnt++.
  - Emit when acc_last=1 or beat_cnt reaches MAX_BEATS: out_valid=1, then return to IDLE.
  - acc_mode=0 beat arriving in ACCUM: the current accumulation is terminated. The new beat is added in as its last beat and the result is emitted.
- Saturation:
  - Unsigned: clamp to 2^OW-1.
  - Signed: clamp to [-2^(OW-1), 2^(OW-1)-1].
  - sat_flag[k] is sticky for the duration of one accumulation.
- Output register holds c_bus/sat_flag stable while out_valid & ~out_ready. No beat is lost or duplicated under backpressure.
- out_valid drops the cycle after acceptance unless a new result is emitted in the same cycle. Back-to-back throughput is 1 beat per clock.
- Single-beat products never saturate for GUARD>=0.

Decomposition:
- Package opm_pkg holds:
  - localparam helpers: OW calc, element index function k=i*B_CNT+j.
  - Accumulator state enum (IDLE, ACCUM).
  - Saturation limit constants as functions of OW and signedness.
- Sub-module opm_mac_cell: one element. It takes registered a[i] and b[j] plus mode tags and produces the product, accumulate/saturate logic, acc register and sat bit. It is instantiated A_CNT*B_CNT times in a generate loop. The top level holds the handshake, beat counter and FSM.

Test Plan:
- Unsigned, acc_mode=0: a=(1,2,3), b=(4,5,6) -> two cycles later c=(4,5,6,8,10,12,12,15,18), sat_flag=0.
- Signed, acc_mode=0: a0=8'hFF, b0=8'h80 -> c0=17'd128; a0=8'h80, b0=8'h7F -> c0=-16256 (17'h1C080).
- Unsigned accumulate, all a=b=255, 3 beats, acc_last on beat 3: partial sums 65025, then 130050. Final c=131071 for every element, all sat_flag=1, exactly one out_valid pulse.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, c_bus stable. On release, results appear in order, none dropped.
- MAX_BEATS=4, acc_mode=1, acc_last never asserted, a=b=1 -> emit after beat 4 with c=4 everywhere. The next beat starts a new accumulation.
- Assert reset=0 mid-accumulation after 2 beats -> out_valid=0 and c_bus=0 immediately. The next single acc_last beat a=b=2 yields c=4, not a stale sum.
